seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//  Programmable Moore sequence detector: generalised successor of the fixed "110" detector.
//  - Pattern bits and pattern length (1..MAX_LEN) are loaded at run time.
//  - Overlapping or non-overlapping detection is run-time selectable.
//  - Input bits are qualified by a valid strobe.
//  - Sits on a serial bit stream; the registered out pulse feeds downstream framing/sync logic.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=2)
//  CNT_W    8  width of hit counter (HIT_COUNT_EN only)
//  LW       $clog2(MAX_LEN+1)  localparam, width of cfg_len
// PORTS
//  clk      in   1        clock, rising edge
//  rst      in   1        asynchronous, active-low reset
//  cfg_we   in   1        load cfg_pat/cfg_len/cfg_ovl this cycle
//  cfg_pat  in   MAX_LEN  pattern; bit [len-1] = first bit received, bit [0] = last bit received
//  cfg_len  in   LW       pattern length; 0 = detector disabled
//  cfg_ovl  in   1        1 = overlapping detection, 0 = non-overlapping
//  x_vld    in   1        x_in is sampled only when high
//  x_in     in   1        serial data bit
//  out      out  1        Moore detect pulse (high while FSM in S_HIT)
//  cnt_clr  in   1        clear hit counter (HIT_COUNT_EN only)
//  hit_cnt  out  CNT_W    saturating hit count (HIT_COUNT_EN only)
// BEHAVIOUR
//  - Reset (rst=0, async): pat=0, len=0, ovl=0, hist=0, fill=0, state=S_IDLE, out=0, hit_cnt=0.
//  - Config: on cfg_we, pat/len/ovl are registered, hist and fill are cleared,
//    state -> S_IDLE if cfg_len==0, else S_SCAN.
//    - cfg_len>MAX_LEN is clamped to MAX_LEN.
//    - cfg_we has priority: a coincident x_vld bit is discarded.
//  - History: on accepted bit (x_vld=1, not cfg_we, state!=S_IDLE):
//    - hist <= {hist[MAX_LEN-2:0], x_in}.
//    - fill <= min(fill+1, MAX_LEN).
//  - Match (combinational on next hist/fill): next_hist[len-1:0]==pat[len-1:0] && next_fill>=len.
//  - FSM states: S_IDLE, S_SCAN, S_HIT.
//    - S_IDLE: stays put until cfg_we with len!=0; x_in is ignored.
//    - S_SCAN -> S_HIT on accepted bit with match; otherwise stays in S_SCAN.
//    - S_HIT -> S_HIT on accepted bit with match (back-to-back hit).
//    - S_HIT -> S_SCAN otherwise, including x_vld=0, so out is a 1-cycle pulse per detection.
//  - Latency: out=1 in the cycle after the clock edge that samples the completing bit.
//    out = (state==S_HIT) purely; no combinational path from inputs.
//  - Non-overlap (ovl=0): entering S_HIT forces fill<=0; the next hit needs len fresh bits.
//  - Overlap (ovl=1): fill is kept, so e.g. 1010 in stream 101010 hits at bits 4 and 6.
//  - len==1: every accepted bit equal to pat[0] hits; ovl has no effect.
//  - Reset asserted mid-stream aborts immediately; pattern must be reloaded after reset.
// CONFIGURATION
//  HIT_COUNT_EN defined:
//    - hit_cnt increments on every S_HIT entry or re-entry (each detection).
//    - hit_cnt saturates at all-ones.
//    - cnt_clr clears it; cnt_clr wins over a simultaneous hit.
//  HIT_COUNT_EN undefined:
//    - cnt_clr and hit_cnt ports are absent; no counter logic.
//    - Detection behaviour is identical.
// TESTING
//  T1: cfg len=3 pat=3'b110 ovl=0; bits 1,1,0,1,1,0 every cycle -> out pulses 1 cycle after bits 3 and 6 only.
//  T2: pat=4'b1010 len=4; bits 1,0,1,0,1,0 -> ovl=1: hits after bits 4 and 6; ovl=0: hit after bit 4 only.
//  T3: pat 110 with x_vld low 2 cycles between each bit -> out after 3rd valid bit, high exactly 1 cycle.
//  T4: len=8 pat=8'hA5; stream 0xA5 MSB-first then 0x00 -> one pulse; len=0 or rst mid-stream -> out stays 0.
//  T5: cfg_we coincident with the completing bit -> no pulse; history cleared (fill=0).
//  T6 (HIT_COUNT_EN, CNT_W=2): 5 hits -> hit_cnt=3 (saturated); cnt_clr on a hit cycle -> hit_cnt=0.

Source files
------------

// File: rtl/seq_det_prog.sv
// Programmable Moore sequence detector with run-time pattern, length and overlap mode.
// Define HIT_COUNT_EN to add the saturating hit counter (cnt_clr / hit_cnt ports).
module seq_det_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_ovl,
  input  logic               x_vld,
  input  logic               x_in,
`ifdef HIT_COUNT_EN
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_cnt,
`endif
  output logic               out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;

  localparam logic [LW-1:0] L_MAX = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_len;
  logic [LW-1:0]      r_fill;
  logic               r_ovl;
  logic [1:0]         r_state;

  logic               w_acc;
  logic               w_match;
  logic [MAX_LEN-1:0] w_nhist;
  logic [MAX_LEN-1:0] w_mask;
  logic [LW-1:0]      w_nfill;
  logic [LW-1:0]      w_len;

  assign w_len = (cfg_len > L_MAX) ? L_MAX : cfg_len;

  assign w_acc = x_vld && !cfg_we &&
                 (r_state != S_IDLE);

  assign w_nhist = {r_hist[MAX_LEN-2:0], x_in};

  assign w_nfill = (r_fill >= L_MAX) ? L_MAX
                 : r_fill + 1'b1;

  // Only the low len bits of the history take part.
  assign w_mask = ~({MAX_LEN{1'b1}} << r_len);

  assign w_match = (r_len != '0) &&
                   (((w_nhist ^ r_pat) & w_mask) == '0) &&
                   (w_nfill >= r_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= S_IDLE;
    end else if (cfg_we) begin
      r_pat   <= cfg_pat;
      r_len   <= w_len;
      r_ovl   <= cfg_ovl;
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= (w_len == '0) ? S_IDLE : S_SCAN;
    end else if (w_acc) begin
      r_hist <= w_nhist;
      if (w_match) begin
        r_state <= S_HIT;
        r_fill  <= r_ovl ? w_nfill : '0;
      end else begin
        r_state <= S_SCAN;
        r_fill  <= w_nfill;
      end
    end else if (r_state == S_HIT) begin
      r_state <= S_SCAN;
    end
  end

  assign out = (r_state == S_HIT);

`ifdef HIT_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_acc && w_match &&
                 (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hit_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: vector table, corner sequences, random vs model.
// Counter checks are compiled in when HIT_COUNT_EN is defined.
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_ovl;
  logic       x_vld;
  logic       x_in;
  logic       out;
`ifdef HIT_COUNT_EN
  logic       cnt_clr;
  logic [1:0] hit_cnt;
`endif

  always #5 clk = ~clk;

  seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_pat (cfg_pat),
    .cfg_len (cfg_len),
    .cfg_ovl (cfg_ovl),
    .x_vld   (x_vld),
    .x_in    (x_in),
`ifdef HIT_COUNT_EN
    .cnt_clr (cnt_clr),
    .hit_cnt (hit_cnt),
`endif
    .out     (out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h",
               nm, got, exp);
    end
  endtask

  // Model: detection from the list of accepted bits.
  bit         m_en;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  bit         m_out;
  int         m_cnt;

  task automatic model_reset();
    m_en  = 0;
    m_pat = '0;
    m_len = 0;
    m_ovl = 0;
    m_q.delete();
    m_out = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic we,
                            input logic [7:0] pat,
                            input logic [3:0] len,
                            input logic ovl,
                            input logic vld,
                            input logic x,
                            input logic clr);
    bit hit = 0;
    if (we) begin
      m_pat = pat;
      m_len = (len > 8) ? 8 : int'(len);
      m_ovl = ovl;
      m_q.delete();
      m_en  = (m_len != 0);
    end else if (m_en && vld) begin
      m_q.push_back(x);
      if (m_q.size() > 8) void'(m_q.pop_front());
      hit = (m_q.size() >= m_len);
      if (hit)
        for (int i = 0; i < m_len; i++)
          if (m_q[m_q.size() - m_len + i] !=
              m_pat[m_len - 1 - i]) hit = 0;
      if (hit && !m_ovl) m_q.delete();
    end
    m_out = hit;
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < 3) m_cnt++;
  endtask

  task automatic step(input logic we,
                      input logic [7:0] pat,
                      input logic [3:0] len,
                      input logic ovl,
                      input logic vld,
                      input logic x,
                      input logic clr);
    cfg_we  = we;
    cfg_pat = pat;
    cfg_len = len;
    cfg_ovl = ovl;
    x_vld   = vld;
    x_in    = x;
`ifdef HIT_COUNT_EN
    cnt_clr = clr;
`endif
    @(posedge clk);
    model_edge(we, pat, len, ovl, vld, x, clr);
    #1;
    chk("model out", 32'(out), 32'(m_out));
`ifdef HIT_COUNT_EN
    chk("model cnt", 32'(hit_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic cfg(input logic [7:0] p,
                     input logic [3:0] l,
                     input logic o);
    step(1'b1, p, l, o, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sb(input logic v, input logic b);
    step(1'b0, 8'h00, 4'd0, 1'b0, v, b, 1'b0);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       vld;
    logic       x;
    logic       exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic we,
                     input logic [7:0] pat,
                     input logic [3:0] len,
                     input logic ovl,
                     input logic vld,
                     input logic x,
                     input logic exp);
    tbl.push_back('{we, pat, len, ovl, vld, x, exp});
  endtask

  task automatic ab(input logic b, input logic e);
    add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, e);
  endtask

  initial begin
    logic [7:0] a5;
    logic [3:0] rl;
    a5 = 8'hA5;

    rst = 1'b0;
    cfg_we = 0; cfg_pat = 0; cfg_len = 0;
    cfg_ovl = 0; x_vld = 0; x_in = 0;
`ifdef HIT_COUNT_EN
    cnt_clr = 0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", 32'(out), 32'd0);
`ifdef HIT_COUNT_EN
    chk("reset cnt", 32'(hit_cnt), 32'd0);
`endif
    rst = 1'b1;

    // T1: 110, non-overlap
    add(1, 8'b110, 3, 0, 0, 0, 0);
    ab(1, 0); ab(1, 0); ab(0, 1);
    ab(1, 0); ab(1, 0); ab(0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // T2: 1010 overlap then non-overlap
    add(1, 8'b1010, 4, 1, 0, 0, 0);
    ab(1, 0); ab(0, 0); ab(1, 0);
    ab(0, 1); ab(1, 0); ab(0, 1);
    add(1, 8'b1010, 4, 0, 0, 0, 0);
    ab(1, 0); ab(0, 0); ab(1, 0);
    ab(0, 1); ab(1, 0); ab(0, 0);
    // T4: A5 full length, then zeros
    add(1, 8'hA5, 8, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) ab(a5[i], i == 0);
    for (int i = 0; i < 8; i++) ab(0, 0);
    // len above MAX_LEN clamps to 8
    add(1, 8'hA5, 15, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) ab(a5[i], i == 0);
    // len 0 disables
    add(1, 8'b110, 0, 0, 0, 0, 0);
    ab(1, 0); ab(1, 0); ab(0, 0);
    // len 1, back-to-back hits
    add(1, 8'h01, 1, 0, 0, 0, 0);
    ab(1, 1); ab(1, 1); ab(0, 0); ab(1, 1);
    add(1, 8'hFE, 1, 1, 0, 0, 0);
    ab(0, 1); ab(1, 0); ab(0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].pat, tbl[i].len,
           tbl[i].ovl, tbl[i].vld, tbl[i].x, 1'b0);
      chk($sformatf("tbl[%0d]", i),
          32'(out), 32'(tbl[i].exp));
    end

    // T3: gaps of x_vld low, x ignored there
    cfg(8'b110, 3, 0);
    sb(1, 1); sb(0, 1); sb(0, 0);
    sb(1, 1); sb(0, 0); sb(0, 1);
    chk("t3 gap", 32'(out), 32'd0);
    sb(1, 0);
    chk("t3 hit", 32'(out), 32'd1);
    sb(0, 0);
    chk("t3 pulse", 32'(out), 32'd0);
    sb(0, 0);
    chk("t3 quiet", 32'(out), 32'd0);

    // T5: cfg_we on the completing bit
    cfg(8'b110, 3, 0);
    sb(1, 1); sb(1, 1);
    step(1'b1, 8'b110, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5 no pulse", 32'(out), 32'd0);
    sb(1, 0);
    chk("t5 cleared", 32'(out), 32'd0);
    sb(1, 1); sb(1, 1); sb(1, 0);
    chk("t5 rehit", 32'(out), 32'd1);

    // async reset while out is high
    cfg(8'b110, 3, 0);
    sb(1, 1); sb(1, 1); sb(1, 0);
    chk("pre rst hit", 32'(out), 32'd1);
    #2 rst = 1'b0;
    #1 chk("rst async", 32'(out), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    sb(1, 1); sb(1, 1); sb(1, 0);
    chk("no reload", 32'(out), 32'd0);

`ifdef HIT_COUNT_EN
    // T6: saturation and clear priority
    cfg(8'h01, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) sb(1, 1);
    chk("t6 sat", 32'(hit_cnt), 32'd3);
    step(0, 0, 0, 0, 1, 1, 1);
    chk("t6 clr", 32'(hit_cnt), 32'd0);
    chk("t6 out", 32'(out), 32'd1);
`endif

    // random stream against the model
    for (int n = 0; n < 600; n++) begin
      if (n == 0 || $urandom_range(0, 40) == 0) begin
        rl = ($urandom_range(0, 5) == 0)
           ? 4'($urandom_range(0, 15))
           : 4'($urandom_range(1, 4));
        step(1'b1, 8'($urandom), rl,
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
      end else begin
        step(1'b0, 8'($urandom), 4'($urandom),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)),
             $urandom_range(0, 30) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
